// File: rtl/ex_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_pipe
//  Description : EX/MEM pipeline register chain of STAGES entries. Each entry
//                carries valid, WB, M, ALU, WDATA and RD fields. Stage
//                STAGES-1 drives the outputs. The outputs are registered only,
//                so no input has a combinational path to any output.
//                The control fields (valid, WB, M) are zeroed for bubbles.
//                stall_i holds every stage. flush_i clears the control fields
//                of every stage and overrides stall_i. rst_i overrides both.
//
//  Ports       : clk_i, rst_i       - clock; synchronous active-high reset
//                stall_i, flush_i   - hold all stages / kill all in-flight ops
//                valid_i, WB_i, M_i, ALU_i, WDATA_i, RD_i   - input entry
//                valid_o, WB_o, M_o, ALU_o, WDATA_o, RD_o   - last stage
//                stall_cnt_o, flush_cnt_o - saturating performance counters
//
//  Options     : EX_MEM_PIPE_PERF_CNT_EN - when defined, the performance
//                counters are built. When undefined, both counter outputs
//                are tied to zero and no counter flops exist.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_pipe #(
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int STAGES = 1   // legal range 1..4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [WB_W-1:0]   WB_i,
    input  logic [M_W-1:0]    M_i,
    input  logic [DATA_W-1:0] ALU_i,
    input  logic [DATA_W-1:0] WDATA_i,
    input  logic [REG_W-1:0]  RD_i,
    output logic              valid_o,
    output logic [WB_W-1:0]   WB_o,
    output logic [M_W-1:0]    M_o,
    output logic [DATA_W-1:0] ALU_o,
    output logic [DATA_W-1:0] WDATA_o,
    output logic [REG_W-1:0]  RD_o,
    output logic [15:0]       stall_cnt_o,
    output logic [15:0]       flush_cnt_o
);

    logic              r_valid [STAGES];
    logic [WB_W-1:0]   r_wb    [STAGES];
    logic [M_W-1:0]    r_m     [STAGES];
    logic [DATA_W-1:0] r_alu   [STAGES];
    logic [DATA_W-1:0] r_wdata [STAGES];
    logic [REG_W-1:0]  r_rd    [STAGES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_wb[i]    <= '0;
                r_m[i]     <= '0;
                r_alu[i]   <= '0;
                r_wdata[i] <= '0;
                r_rd[i]    <= '0;
            end
        end else if (flush_i) begin
            // Only the control fields are killed. The data fields are left
            // unchanged because a bubble never consumes them.
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_wb[i]    <= '0;
                r_m[i]     <= '0;
            end
        end else if (!stall_i) begin
            // Gate control at entry so a bubble can never write a register
            // or memory downstream. The data fields still load as presented.
            r_valid[0] <= valid_i;
            r_wb[0]    <= valid_i ? WB_i : '0;
            r_m[0]     <= valid_i ? M_i  : '0;
            r_alu[0]   <= ALU_i;
            r_wdata[0] <= WDATA_i;
            r_rd[0]    <= RD_i;
            for (int i = 1; i < STAGES; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_wb[i]    <= r_wb[i-1];
                r_m[i]     <= r_m[i-1];
                r_alu[i]   <= r_alu[i-1];
                r_wdata[i] <= r_wdata[i-1];
                r_rd[i]    <= r_rd[i-1];
            end
        end
    end

    assign valid_o = r_valid[STAGES-1];
    assign WB_o    = r_wb[STAGES-1];
    assign M_o     = r_m[STAGES-1];
    assign ALU_o   = r_alu[STAGES-1];
    assign WDATA_o = r_wdata[STAGES-1];
    assign RD_o    = r_rd[STAGES-1];

`ifdef EX_MEM_PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic [15:0] w_nvalid;

    // Sum with clamp. The counters stick at all-ones instead of wrapping.
    function automatic logic [15:0] f_sat_add(input logic [15:0] a,
                                              input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Number of live entries that a flush on this edge would discard.
    always_comb begin
        w_nvalid = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_nvalid = w_nvalid + {15'd0, r_valid[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (flush_i) begin
            r_flush_cnt <= f_sat_add(r_flush_cnt, w_nvalid);
        end else if (stall_i) begin
            r_stall_cnt <= f_sat_add(r_stall_cnt, 16'd1);
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = 16'd0;
    assign flush_cnt_o = 16'd0;
`endif

endmodule
`default_nettype wire
